srambank_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one synchronous SRAM bank (1024x74, 1-cycle registered read)

---
 rtl/srambank_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_srambank_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/srambank_rr_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency SRAM bank among NREQ valid/ready requesters.
// Optional zero-fill sweep after reset when SRAMBANK_ARB_INIT_EN is defined.
module srambank_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 10,
  parameter int unsigned DW   = 74
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic [AW-1:0]     bank_addr,
  output logic [DW-1:0]     bank_wd,
  output logic              bank_sel,
  output logic              bank_read,
  output logic              bank_write,
  input  logic [DW-1:0]     bank_dataout,
  output logic              init_busy
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            run;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt_oh;

`ifdef SRAMBANK_ARB_INIT_EN
  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + AW'(1);
      if (&cnt_q) state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run       = ~reset & (state_q == StRun);
  assign init_busy = reset | (state_q == StInit);
`else
  assign run       = ~reset;
  assign init_busy = 1'b0;
`endif

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(cand);
      end
    end
    gnt_any = gnt_any & run;
  end

  assign gnt_oh    = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  assign req_ready = gnt_oh;

  always_comb begin
    bank_sel   = 1'b0;
    bank_read  = 1'b0;
    bank_write = 1'b0;
    bank_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    bank_wd    = req_wdata[int'(gnt_idx)*DW +: DW];
    if (gnt_any) begin
      bank_sel   = 1'b1;
      bank_write = req_write[gnt_idx];
      bank_read  = ~req_write[gnt_idx];
    end
`ifdef SRAMBANK_ARB_INIT_EN
    if (!reset && state_q == StInit) begin
      bank_sel   = 1'b1;
      bank_write = 1'b1;
      bank_read  = 1'b0;
      bank_addr  = cnt_q;
      bank_wd    = '0;
    end
`endif
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = '0;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      if (!req_write[gnt_idx]) rsp_valid_d = gnt_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Gating by reset drops a response already registered when reset arrives.
  assign rsp_valid = reset ? '0 : rsp_valid_q;
  assign rsp_rdata = bank_dataout;

endmodule

// File: tb/tb_srambank_rr_arbiter.sv
// Self-checking bench for srambank_rr_arbiter: behavioural bank plus reference model,
// directed scenarios and randomized traffic.
module tb_srambank_rr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 74;
`ifdef SRAMBANK_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rsp_rdata, bank_wd, bank_dataout;
  logic [AW-1:0]      bank_addr;
  logic               bank_sel, bank_read, bank_write, init_busy;

  srambank_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bank_addr(bank_addr), .bank_wd(bank_wd), .bank_sel(bank_sel),
    .bank_read(bank_read), .bank_write(bank_write), .bank_dataout(bank_dataout),
    .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pre_val(input int i);
    if (i == 5) return 74'h3FF;
    return (DW'(i) * DW'(37)) ^ 74'h155;
  endfunction

  // Behavioural SRAM bank with registered read.
  logic [DW-1:0] bank_mem [1024];
  bit            mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) bank_mem[i] <= pre_val(i);
      mem_loaded <= 1'b1;
    end else begin
      if (bank_sel && bank_write) bank_mem[bank_addr] <= bank_wd;
      if (bank_sel && bank_read) bank_dataout <= bank_mem[bank_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [DW-1:0]   shadow [1024];
  int              m_ptr;
  int              m_init;
  logic [NREQ-1:0] m_rsp_v;
  logic [DW-1:0]   m_rsp_d;
  int              last_g;

  // Requester-side stimulus.
  logic            v [NREQ];
  logic            w [NREQ];
  logic [AW-1:0]   a [NREQ];
  logic [DW-1:0]   d [NREQ];

  logic [NREQ-1:0] snap_ready, snap_rsp_v;
  logic [DW-1:0]   snap_rdata;
  logic            snap_sel;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check at negedge against the model, advance the model.
  task automatic step(input logic rst);
    int              g;
    logic [NREQ-1:0] er;
    reset = rst;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = v[i];
      req_write[i]           = w[i];
      req_addr[i*AW +: AW]   = a[i];
      req_wdata[i*DW +: DW]  = d[i];
    end
    @(negedge clk);
    g = -1;
    if (!rst && m_init == 0)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    er = (g >= 0) ? (NREQ'(1) << g) : '0;
    snap_ready = req_ready;
    snap_rsp_v = rsp_valid;
    snap_rdata = rsp_rdata;
    snap_sel   = bank_sel;
    chk("req_ready", DW'(req_ready), DW'(er));
    chk("bank_sel", DW'(bank_sel), DW'((g >= 0) || (m_init > 0 && !rst)));
    chk("rsp_valid", DW'(rsp_valid), rst ? '0 : DW'(m_rsp_v));
    if (!rst && m_rsp_v != '0) chk("rsp_rdata", rsp_rdata, m_rsp_d);
    chk("init_busy", DW'(init_busy), DW'(INIT_EN && (rst || m_init > 0)));
    chk("rd_wr_excl", DW'(bank_read & bank_write), '0);
    if (g >= 0) begin
      chk("bank_addr", DW'(bank_addr), DW'(a[g]));
      chk("bank_write", DW'(bank_write), DW'(w[g]));
      chk("bank_read", DW'(bank_read), DW'(!w[g]));
      if (w[g]) chk("bank_wd", bank_wd, d[g]);
    end else if (m_init > 0 && !rst) begin
      chk("init_write", DW'(bank_write), DW'(1));
      chk("init_addr", DW'(bank_addr), DW'(1024 - m_init));
      chk("init_wd", bank_wd, '0);
    end
    if (rst) begin
      m_ptr   = 0;
      m_rsp_v = '0;
      m_init  = INIT_EN ? 1024 : 0;
    end else if (m_init > 0) begin
      shadow[1024 - m_init] = '0;
      m_init--;
      m_rsp_v = '0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      if (w[g]) begin
        shadow[a[g]] = d[g];
        m_rsp_v      = '0;
      end else begin
        m_rsp_v = er;
        m_rsp_d = shadow[a[g]];
      end
    end else begin
      m_rsp_v = '0;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0;
    end
  endtask

  task automatic drain_init();
    while (m_init > 0) step(1'b0);
  endtask

  initial begin
    logic [95:0] r;
    for (int i = 0; i < 1024; i++) shadow[i] = pre_val(i);
    m_ptr = 0; m_init = 0; m_rsp_v = '0; m_rsp_d = '0; last_g = -1;
    idle_all();
    reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk);
    #1;
    step(1'b1);
    step(1'b1);
    chk("reset_rsp_valid", DW'(snap_rsp_v), '0);
    chk("reset_bank_sel", DW'(snap_sel), '0);
    drain_init();

    // Single read of address 5.
    v[0] = 1'b1; w[0] = 1'b0; a[0] = 10'd5;
    step(1'b0);
    chk("t1_ready", DW'(snap_ready), DW'(4'b0001));
    idle_all();
    step(1'b0);
    chk("t1_rsp_valid", DW'(snap_rsp_v), DW'(4'b0001));
    chk("t1_rdata", snap_rdata, INIT_EN ? '0 : 74'h3FF);

    // Write then read of address 1023 on consecutive cycles.
    v[2] = 1'b1; w[2] = 1'b1; a[2] = 10'd1023; d[2] = 74'h1_2345;
    step(1'b0);
    chk("t3_wr_ready", DW'(snap_ready), DW'(4'b0100));
    idle_all();
    v[1] = 1'b1; w[1] = 1'b0; a[1] = 10'd1023;
    step(1'b0);
    idle_all();
    step(1'b0);
    chk("t3_rsp_valid", DW'(snap_rsp_v), DW'(4'b0010));
    chk("t3_rdata", snap_rdata, 74'h1_2345);

    // Idle skip: bring ptr to 1, then only req3, then req0+req3.
    v[0] = 1'b1; a[0] = 10'd0;
    step(1'b0);
    idle_all();
    step(1'b0);
    v[3] = 1'b1; a[3] = 10'd7;
    step(1'b0);
    chk("t4_skip", DW'(snap_ready), DW'(4'b1000));
    v[0] = 1'b1; a[0] = 10'd8;
    step(1'b0);
    chk("t4_wrap", DW'(snap_ready), DW'(4'b0001));
    idle_all();

    // Reset right after a read grant drops the response.
    v[1] = 1'b1; a[1] = 10'd9;
    step(1'b0);
    idle_all();
    step(1'b1);
    chk("t5_rsp_dropped", DW'(snap_rsp_v), '0);
    chk("t5_bank_sel", DW'(snap_sel), '0);
    drain_init();
    step(1'b0);
    chk("t5_rsp_after", DW'(snap_rsp_v), '0);

    // Fairness with every requester reading continuously from reset.
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b1; w[i] = 1'b0; a[i] = AW'(20 + i);
    end
    for (int c = 0; c < 8; c++) begin
      step(1'b0);
      chk("t2_fair", DW'(snap_ready), DW'(NREQ'(1) << (c % NREQ)));
    end

    // Randomized traffic; requests are held until granted.
    idle_all();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || last_g == i) begin
          r    = {$urandom, $urandom, $urandom};
          v[i] = ($urandom_range(0, 99) < 55);
          w[i] = $urandom_range(0, 1) == 1;
          a[i] = AW'($urandom_range(0, 15));
          d[i] = r[DW-1:0];
        end
      end
      step($urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
